// File: rtl/divide_tokens.sv
// Multi-lane token divider: each lane forwards every Nth '1' token, N programmable 1..MAX_DIV.
// Define DIVIDE_TOKENS_REG_OUT_EN to register b (one cycle of added latency).
module divide_tokens #(
   parameter  int CHANNELS = 4,
   parameter  int MAX_DIV  = 8,
   localparam int DIV_W    = $clog2(MAX_DIV + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [DIV_W-1:0]    div,
   input  logic [CHANNELS-1:0] a,
   output logic [CHANNELS-1:0] b,
   output logic [DIV_W-1:0]    div_cur
);

   logic [DIV_W-1:0]    div_reg;
   logic [DIV_W-1:0]    div_next;
   logic [DIV_W-1:0]    div_last;
   logic [DIV_W-1:0]    cnt_reg  [CHANNELS];
   logic [DIV_W-1:0]    cnt_next [CHANNELS];
   logic [CHANNELS-1:0] hit;
   logic [CHANNELS-1:0] b_next;

   // Clamp the requested divisor into the legal 1..MAX_DIV range on load.
   always_comb begin
      div_next = div_reg;
      if (load) begin
         if (div == '0)
            div_next = DIV_W'(1);
         else if (div > DIV_W'(MAX_DIV))
            div_next = DIV_W'(MAX_DIV);
         else
            div_next = div;
      end
   end

   assign div_last = div_reg - DIV_W'(1);

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
         // Tokens arriving in a load cycle are dropped and not counted.
         assign hit[gi]      = !load && a[gi] && (cnt_reg[gi] == div_last);
         assign b_next[gi]   = hit[gi] && !rst;
         assign cnt_next[gi] = load    ? '0 :
                               hit[gi] ? '0 :
                               a[gi]   ? cnt_reg[gi] + DIV_W'(1) :
                                         cnt_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg <= DIV_W'(2);
         for (int i = 0; i < CHANNELS; i++)
            cnt_reg[i] <= '0;
      end else begin
         div_reg <= div_next;
         for (int i = 0; i < CHANNELS; i++)
            cnt_reg[i] <= cnt_next[i];
      end
   end

`ifdef DIVIDE_TOKENS_REG_OUT_EN
   logic [CHANNELS-1:0] b_reg;

   always_ff @(posedge clk) begin
      if (rst)
         b_reg <= '0;
      else
         b_reg <= b_next;
   end

   assign b = b_reg;
`else
   assign b = b_next;
`endif

   assign div_cur = div_reg;

endmodule

// File: tb/tb_divide_tokens.sv
// Self-checking bench for divide_tokens: vector table plus hand-written corner sequences.
module tb_divide_tokens;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [3:0] div = '0;
   logic [3:0] a = '0;
   logic [3:0] b;
   logic [3:0] div_cur;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [3:0] prev_exp = '0;

   typedef struct {
      logic       r;
      logic       l;
      logic [3:0] dv;
      logic [3:0] av;
      logic [3:0] eb;
      logic [3:0] ed;
   } vec_t;

   vec_t vecs[$];

   divide_tokens #(.CHANNELS(4), .MAX_DIV(8)) dut (
      .clk(clk), .rst(rst), .load(load), .div(div), .a(a), .b(b), .div_cur(div_cur)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic r, l, input logic [3:0] dv, av, eb, ed);
      vec_t v;
      v.r = r; v.l = l; v.dv = dv; v.av = av; v.eb = eb; v.ed = ed;
      vecs.push_back(v);
   endfunction

   // Drive one cycle, compare at the falling edge, return just after the next rising edge.
   task automatic step(input logic r, l, input logic [3:0] dv, av, eb, ed, input string nm);
      logic [3:0] want;
      rst = r; load = l; div = dv; a = av;
      @(negedge clk);
`ifdef DIVIDE_TOKENS_REG_OUT_EN
      want = prev_exp;
`else
      want = eb;
`endif
      prev_exp = eb;
      checks++;
      if (b !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d b got %b want %b", nm, cyc, b, want);
      end
      checks++;
      if (div_cur !== ed) begin
         errors++;
         $display("FAIL %s_div cyc=%0d div_cur got %0d want %0d", nm, cyc, div_cur, ed);
      end
      $display("cyc=%0d %s rst=%b load=%b div=%0d a=%b b=%b div_cur=%0d", cyc, nm, r, l, dv, av, b, div_cur);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] ap1, bp1;
      logic [6:0]  bp2;
      logic [15:0] pats [4];
      logic [3:0]  par;
      logic [3:0]  av, eb;

      // Halve mode after reset on lane 0.
      ap1 = 16'b1100111010001111;
      bp1 = 16'b0100010010000101;
      add(1, 0, 0, 4'b0000, 4'b0000, 2);
      for (int i = 15; i >= 0; i--)
         add(0, 0, 0, {3'b000, ap1[i]}, {3'b000, bp1[i]}, 2);
      // Divide by 3 on lane 1.
      bp2 = 7'b0010010;
      add(0, 1, 3, 4'b0000, 4'b0000, 2);
      for (int i = 6; i >= 0; i--)
         add(0, 0, 0, 4'b0010, {2'b00, bp2[i], 1'b0}, 3);
      // div=0 clamps to 1: everything passes.
      add(0, 1, 0, 4'b0000, 4'b0000, 3);
      for (int i = 0; i < 3; i++)
         add(0, 0, 0, 4'b1111, 4'b1111, 1);
      // div=15 clamps to 8 on lane 3.
      add(0, 1, 15, 4'b0000, 4'b0000, 1);
      for (int i = 0; i < 16; i++)
         add(0, 0, 0, 4'b1000, (i == 7 || i == 15) ? 4'b1000 : 4'b0000, 8);

      @(posedge clk);
      #1;
      foreach (vecs[k])
         step(vecs[k].r, vecs[k].l, vecs[k].dv, vecs[k].av, vecs[k].eb, vecs[k].ed, "table");

      // Reload mid-group: token in the load cycle is dropped, count restarts.
      step(0, 1, 3, 4'b0000, 4'b0000, 8, "reload_set");
      step(0, 0, 0, 4'b0100, 4'b0000, 3, "reload_pre1");
      step(0, 0, 0, 4'b0100, 4'b0000, 3, "reload_pre2");
      step(0, 1, 3, 4'b0100, 4'b0000, 3, "reload_load");
      step(0, 0, 0, 4'b0100, 4'b0000, 3, "reload_t1");
      step(0, 0, 0, 4'b0100, 4'b0000, 3, "reload_t2");
      step(0, 0, 0, 4'b0100, 4'b0100, 3, "reload_t3");

      // Reset mid-group, with load asserted too: reset wins, divisor back to 2.
      step(0, 1, 4, 4'b0000, 4'b0000, 3, "rst_set");
      step(0, 0, 0, 4'b0001, 4'b0000, 4, "rst_pre1");
      step(0, 0, 0, 4'b0001, 4'b0000, 4, "rst_pre2");
      step(0, 0, 0, 4'b0001, 4'b0000, 4, "rst_pre3");
      step(1, 1, 7, 4'b0001, 4'b0000, 4, "rst_pulse");
      step(0, 0, 0, 4'b0001, 4'b0000, 2, "rst_t1");
      step(0, 0, 0, 4'b0001, 4'b0001, 2, "rst_t2");

      // Concurrent lanes at div=2 against an independent parity model per lane.
      step(0, 1, 2, 4'b0000, 4'b0000, 2, "multi_load");
      pats[0] = 16'hB3C5;
      pats[1] = 16'h6E19;
      pats[2] = 16'hF0F0;
      pats[3] = 16'h5A5A;
      par = '0;
      for (int t = 0; t < 16; t++) begin
         for (int ln = 0; ln < 4; ln++) begin
            av[ln] = pats[ln][t];
            eb[ln] = av[ln] & par[ln];
            if (av[ln])
               par[ln] = ~par[ln];
         end
         step(0, 0, 0, av, eb, 2, "multi");
      end
      step(0, 0, 0, 4'b0000, 4'b0000, 2, "flush");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divide_tokens.md
Name: divide_tokens

Overview:
- Serial multi-channel token divider. On each of CHANNELS independent 1-bit lanes, it forwards only every Nth incoming '1' token and suppresses the rest.
- N is runtime-programmable, from 1 to MAX_DIV.
- Generalises the fixed halve-by-2 token filter; a divisor of 2 reproduces that behaviour exactly.
- Sits in the sequential-basics token-processing path, between a token source and rate-reduced consumers.

Parameters:
- CHANNELS, 4, number of independent token lanes (>=1).
- MAX_DIV, 8, largest supported divisor (>=2).
- DIV_W, $clog2(MAX_DIV+1), width of divisor port and per-lane counters (derived, do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  one-cycle strobe: capture div into div_r and clear all lane counters.
- div  input  DIV_W  requested divisor, sampled only when load=1.
- a  input  CHANNELS  incoming token per lane, 1 = token.
- b  output  CHANNELS  forwarded token per lane.
- div_cur  output  DIV_W  currently active divisor (div_r).

Behaviour:
- State: div_r (DIV_W bits); cnt[i] (DIV_W bits) per lane, range 0..div_r-1.
- Reset (rst=1 at posedge):
  - div_r <= 2 (halve mode); all cnt[i] <= 0.
  - While rst is high, b = 0 on every lane.
- Divisor capture on load=1 at posedge: div_r <= clamp(div).
  - div=0 gives 1.
  - div>MAX_DIV gives MAX_DIV.
  - Otherwise div_r <= div.
- Per lane i, normal cycle (rst=0, load=0):
  - a[i]=0: b[i]=0; cnt[i] holds.
  - a[i]=1 and cnt[i]==div_r-1: b[i]=1 in the same cycle (combinational, zero latency); cnt[i] <= 0.
  - a[i]=1 and cnt[i]<div_r-1: b[i]=0; cnt[i] <= cnt[i]+1.
- div_r=1: every token passes; cnt stays 0.
- Load cycle: b = 0 on all lanes, a ignored (tokens that cycle are dropped and not counted); all cnt <= 0.
  - The first token after load is token #1 of a new group.
- rst has priority over load.
- Lanes are fully independent; simultaneous tokens on several lanes are each handled per the rules above.
- Counters never exceed div_r-1, so no wrap-around beyond the divisor.
- Reset mid-group discards the partial count.
- div_cur = div_r at all times; reset value 2.

Optional Feature:
- Macro: DIVIDE_TOKENS_REG_OUT_EN.
- Defined: b is registered. The value computed above appears on b one cycle later (latency 1). The b register resets to 0, and the load-cycle output (0) is registered like any other.
- Undefined: b is combinational from a and cnt (latency 0), as specified above.

Test Plan:
- Reset then lane0 a=110_011_101_000_1111 (div_r=2 default) -> b=010_001_001_000_0101, div_cur=2.
- load with div=3, then lane1 a=1 for 7 cycles -> b=0010010 on lane1; lanes 0,2,3 stay 0.
- load with div=0 -> div_cur=1, all tokens pass; load with div=15 (MAX_DIV=8) -> div_cur=8, only the 8th, 16th, ... token passes.
- div=3; send 2 tokens on lane2, assert load (div=3) with a[2]=1 that cycle -> b[2]=0 in the load cycle; the next 3 tokens give b=001 (the count restarted).
- div=4, 3 tokens sent, rst pulsed one cycle -> div_cur=2, cnt cleared; the next 2 tokens give b=01.
- All lanes toggle different patterns concurrently at div=2 -> each lane matches an independent halve model; with DIVIDE_TOKENS_REG_OUT_EN defined, same expected streams shifted by one cycle.
